// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART bus controller and baud generator.
package spart_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 16;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam int unsigned STAT_RDA = 0;
    localparam int unsigned STAT_TBR = 1;
    localparam int unsigned STAT_OVR = 2;

    typedef enum logic {
        DIS = 1'b0,
        RUN = 1'b1
    } baud_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable divisor and down counter producing the 16x oversample enable pulse.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lo_we,
    input  logic              hi_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] div_lo,
    output logic [DATA_W-1:0] div_hi,
    output logic              b_en
);

    localparam logic [DIV_W-1:0] RST_CNT =
        (DEFAULT_DIV == DIV_W'(0)) ? DIV_W'(0) : DEFAULT_DIV - DIV_W'(1);
    localparam baud_state_e RST_STATE = (DEFAULT_DIV == DIV_W'(0)) ? DIS : RUN;

    baud_state_e       state, state_nxt;
    logic [DIV_W-1:0]  cnt, cnt_nxt;
    logic [DIV_W-1:0]  div, div_nxt;
    logic [DATA_W-1:0] lo_shadow, lo_nxt;
    logic              b_en_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RST_STATE;
            cnt       <= RST_CNT;
            div       <= DEFAULT_DIV;
            lo_shadow <= DATA_W'(0);
            b_en      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div       <= div_nxt;
            lo_shadow <= lo_nxt;
            b_en      <= b_en_nxt;
        end
    end

    // A DB_HI commit overrides whatever the counter would have done this cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div;
        lo_nxt    = lo_shadow;
        b_en_nxt  = 1'b0;

        if (lo_we) begin
            lo_nxt = wdata;
        end

        if (hi_we) begin
            div_nxt = {wdata, lo_shadow};
            if (div_nxt != DIV_W'(0)) begin
                state_nxt = RUN;
                cnt_nxt   = div_nxt - DIV_W'(1);
            end else begin
                state_nxt = DIS;
                cnt_nxt   = DIV_W'(0);
            end
        end else begin
            case (state)
                DIS: cnt_nxt = cnt;
                RUN: begin
                    if (cnt == DIV_W'(0)) begin
                        cnt_nxt  = div - DIV_W'(1);
                        b_en_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt - DIV_W'(1);
                    end
                end
                default: state_nxt = DIS;
            endcase
        end
    end

    assign div_lo = div[DATA_W-1:0];
    assign div_hi = div[DIV_W-1:DATA_W];

endmodule

// File: rtl/spart_ctrl.sv
// SPART bus-side controller: register decode, RX holding, TX load and status.
// Optional overrun tracking is built when SPART_OVERRUN_EN is defined.
module spart_ctrl
    import spart_pkg::*;
#(
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_iocs,
    input  logic              i_iorw,
    input  logic [1:0]        i_ioaddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_b_en,
    input  logic              i_rda,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic              o_rx_ack,
    input  logic              i_tbr,
    output logic              o_tx_load,
    output logic [DATA_W-1:0] o_tx_data
);

    logic              rd, wr;
    logic              rd_data, rd_status, wr_data;
    logic              rda_q, rda_rise;
    logic              rda_flag, ovr;
    logic [DATA_W-1:0] rx_hold;
    logic [DATA_W-1:0] div_lo, div_hi;
    logic [DATA_W-1:0] status;

    assign rd        = i_iocs & i_iorw;
    assign wr        = i_iocs & ~i_iorw;
    assign rd_data   = rd & (i_ioaddr == ADDR_DATA);
    assign rd_status = rd & (i_ioaddr == ADDR_STATUS);
    assign wr_data   = wr & (i_ioaddr == ADDR_DATA);
    assign rda_rise  = i_rda & ~rda_q;

    spart_baud_gen #(
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .lo_we  (wr & (i_ioaddr == ADDR_DB_LO)),
        .hi_we  (wr & (i_ioaddr == ADDR_DB_HI)),
        .wdata  (i_wdata),
        .div_lo (div_lo),
        .div_hi (div_hi),
        .b_en   (o_b_en)
    );

    // A new byte always wins over a same-cycle data read, keeping RDA set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rda_q     <= 1'b0;
            rx_hold   <= DATA_W'(0);
            rda_flag  <= 1'b0;
            o_rx_ack  <= 1'b0;
            o_tx_load <= 1'b0;
            o_tx_data <= DATA_W'(0);
        end else begin
            rda_q     <= i_rda;
            o_rx_ack  <= rda_rise;
            o_tx_load <= wr_data & i_tbr;
            if (rda_rise) begin
                rx_hold  <= i_rx_data;
                rda_flag <= 1'b1;
            end else if (rd_data) begin
                rda_flag <= 1'b0;
            end
            if (wr_data && i_tbr) begin
                o_tx_data <= i_wdata;
            end
        end
    end

`ifdef SPART_OVERRUN_EN
    // Overrun only when the previous byte was still unread after this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr <= 1'b0;
        end else if (rda_rise && rda_flag && !rd_data) begin
            ovr <= 1'b1;
        end else if (rd_status) begin
            ovr <= 1'b0;
        end
    end
`else
    assign ovr = 1'b0;
`endif

    always_comb begin
        status           = DATA_W'(0);
        status[STAT_RDA] = rda_flag;
        status[STAT_TBR] = i_tbr;
        status[STAT_OVR] = ovr;
    end

    always_comb begin
        o_rdata = DATA_W'(0);
        if (rd) begin
            case (i_ioaddr)
                ADDR_DATA:   o_rdata = rx_hold;
                ADDR_STATUS: o_rdata = status;
                ADDR_DB_LO:  o_rdata = div_lo;
                ADDR_DB_HI:  o_rdata = div_hi;
                default:     o_rdata = DATA_W'(0);
            endcase
        end
    end

endmodule

// File: doc/spart_ctrl.md
# spart_ctrl

Bus-side controller for the SPART. It decodes processor accesses (`i_iocs`, `i_iorw`, `i_ioaddr`), holds the programmable baud divisor, and generates the single-cycle `o_b_en` 16x-oversample enable that paces the receiver and transmitter. It captures received bytes into a holding register and hands them to the processor. It sequences transmit loads and reports RDA, TBR and overrun status.

## Interface
Parameters:
- `DEFAULT_DIV`, 16'd0: divisor loaded at reset; 0 means `o_b_en` is disabled until the divisor is programmed.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `i_iocs`  in  1  chip select; one-cycle strobe per access
- `i_iorw`  in  1  1 = read, 0 = write
- `i_ioaddr`  in  2  register address
- `i_wdata`  in  8  write data
- `o_rdata`  out  8  read data; combinational
- `o_b_en`  out  1  oversample enable pulse, registered
- `i_rda`  in  1  receiver byte-available level
- `i_rx_data`  in  8  receiver byte
- `o_rx_ack`  out  1  one-cycle pulse that clears the receiver's RDA
- `i_tbr`  in  1  transmit buffer ready
- `o_tx_load`  out  1  one-cycle transmit load pulse
- `o_tx_data`  out  8  transmit byte, registered

## Operation
Address map:
- 00: read returns the RX holding byte; write sends a TX byte.
- 01: read-only status: bit0 RDA, bit1 TBR (live `i_tbr`), bit2 OVR; bits 7:3 read 0. Writes are ignored.
- 10: DB_LO. A write stores the byte into the low shadow only; a read returns the committed low byte.
- 11: DB_HI. A write commits {wdata, low shadow} as the divisor and restarts the counter; a read returns the committed high byte.

Read data:
- `o_rdata` = selected register when `i_iocs & i_iorw`, else 8'h00.
- All side effects take place at the clock edge where `i_iocs` is high.

Baud state machine:
- DIS: divisor == 0; `o_b_en` = 0; counter is held.
- RUN: divisor != 0; 16-bit down counter. When the counter is 0, it reloads divisor-1 and asserts `o_b_en` for the next cycle. Divisor 1 gives continuous `o_b_en`.
- Transitions: a DB_HI commit moves to RUN if the new divisor != 0, else to DIS. A commit loads divisor-1.

RX capture:
- A rising edge of `i_rda` (registered previous value) latches `i_rx_data` into the holding register, sets RDA, and pulses `o_rx_ack` the same cycle.
- A read of addr 00 clears RDA.

TX:
- A write to addr 00 with `i_tbr` = 1 registers `i_wdata` into `o_tx_data` and pulses `o_tx_load`.
- A write with `i_tbr` = 0 is dropped and has no other effect.

## Timing
Reset values:
- `o_b_en` 0, `o_rx_ack` 0, `o_tx_load` 0, `o_tx_data` 8'h00.
- Holding register 8'h00, RDA 0, OVR 0, low shadow 8'h00.
- Divisor = `DEFAULT_DIV`; counter = `DEFAULT_DIV`-1 (or 0 in DIS).

Latency:
- First `o_b_en` after a commit of divisor N occurs N cycles after the commit edge; the period is then N cycles.
- `o_tx_load` and `o_rx_ack` occur 1 cycle after the triggering edge.

Simultaneous events and boundaries:
- Commit in the same cycle the counter reaches 0: the commit wins and `o_b_en` is not pulsed.
- Rising `i_rda` in the same cycle as an addr-00 read: the read returns the old byte, the new byte is latched, RDA stays 1, and OVR is not set.
- DB_LO write then read of addr 10 before DB_HI: the read returns the old committed low byte.
- Reset mid-frame: all state returns to reset values immediately; no spurious `o_b_en` during reset.
- Counter wrap is never reached; the reload replaces decrement below 0.

## Configuration
- `SPART_OVERRUN_EN` defined:
  - A rising `i_rda` while RDA = 1 (and not cleared that cycle) sets OVR and overwrites the holding register.
  - OVR clears on a read of addr 01 (status); the read returns OVR = 1 first.
- Undefined: no overrun logic is built; status bit2 always reads 0; the overwrite behaviour is unchanged.

## Structure
- `spart_pkg` holds:
  - address localparams `ADDR_DATA`, `ADDR_STATUS`, `ADDR_DB_LO`, `ADDR_DB_HI`;
  - status bit indices `STAT_RDA`, `STAT_TBR`, `STAT_OVR`;
  - the baud state enum {DIS, RUN}.
- Sub-module `spart_baud_gen` contains the divisor registers, the DIS/RUN machine, the down counter and `o_b_en`. It takes commit strobe and data inputs from `spart_ctrl`.

## Test plan
- Reset with `DEFAULT_DIV` = 0, write DB_LO = 8'h04, DB_HI = 8'h00 -> `o_b_en` pulses every 4 cycles, first pulse 4 cycles after the DB_HI edge; addr 10 reads 8'h04.
- Divisor 1, then commit divisor 0 -> `o_b_en` high every cycle, then 0 from the cycle after the commit onward.
- `i_rda` rises with `i_rx_data` = 8'hA5 -> `o_rx_ack` pulse; status reads 8'h01 | TBR; addr-00 read returns 8'hA5, then status bit0 = 0.
- Two `i_rda` rising edges (8'h11, 8'h22) with no read, `SPART_OVERRUN_EN` defined -> addr 00 = 8'h22; status bit2 = 1 on the first status read, 0 on the second. Without the macro, bit2 = 0.
- Write addr 00 = 8'h3C with `i_tbr` = 1 -> `o_tx_load` for 1 cycle with `o_tx_data` = 8'h3C. Repeat with `i_tbr` = 0 -> no pulse, `o_tx_data` unchanged.
- Assert `rst` low while divisor 8 is running and RDA = 1 -> all outputs 0 asynchronously; after release, divisor = `DEFAULT_DIV` and status = TBR only.
